uart_tx: RTL
============

# uart_tx

Asynchronous serial transmitter: the transmit-side counterpart of the terminal's `uart` receiver. It accepts bytes on an AXI-stream-style slave port and shifts them out on `txd` as start / data (LSB first) / optional parity / stop bits. Bit timing uses the same 8× prescale convention as the receiver, so one `prescale` value configures both directions. It sits in the `pixel_clk` domain, fed from the terminal side, for example keyboard or status bytes routed through `fifo_async`.

## Interface
- `DATA_WIDTH`, 8, data bits per frame (5–9)
- `clk`  in  1  transmit clock; all logic is on the rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `s_axis_tdata`  in  DATA_WIDTH  byte to send
- `s_axis_tvalid`  in  1  `tdata` is valid
- `s_axis_tready`  out  1  transmitter can accept a byte; registered
- `prescale`  in  16  bit period = `prescale`×8 clocks; 0 is treated as 1
- `parity_en`  in  1  append a parity bit
- `parity_odd`  in  1  1 = odd parity, 0 = even parity
- `two_stop`  in  1  1 = two stop bits, 0 = one stop bit
- `txd`  out  1  serial output; idle high; registered
- `busy`  out  1  a frame is in progress (start bit to last stop bit); registered

Reset values: `s_axis_tready`=0, `txd`=1, `busy`=0.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `tready`=1, `txd`=1, `busy`=0.
- **Handshake:** `tvalid & tready` at a clock edge.
  - Latch `tdata`, `prescale`, `parity_en`, `parity_odd` and `two_stop` into frame registers.
  - Compute parity as XOR of the data bits, inverted when `parity_odd`=1.
  - Go to START.
- **Frozen inputs:** changes to the config inputs or `tdata` after the handshake do not affect the frame in flight.
- **START:** `txd`=0 for one bit period, then DATA.
- **DATA:** `DATA_WIDTH` bits, LSB first, one bit period each. Bit counter width is `$clog2(DATA_WIDTH)`. Then PARITY if `parity_en`, else STOP.
- **PARITY:** `txd`=parity for one bit period, then STOP.
- **STOP:** `txd`=1 for one bit period, or two if `two_stop`. Then IDLE.
- **Bit timer:**
  - 19-bit down-counter, loaded with `max(prescale,1)`×8−1 at each bit start.
  - When it reaches 0, the bit ends and the next state/bit loads on that edge.
  - No overflow: 65535×8 fits in 19 bits.
- **Back-pressure:** `tready`=0 in every state except IDLE. `tvalid` may be held; no data is lost or duplicated.
- **Reset:**
  - Asserting `rstn` low mid-frame forces `txd`=1, `busy`=0, `tready`=0 and the state to IDLE immediately (asynchronously).
  - The partially sent frame is abandoned.
  - On the first edge after release, `tready` goes to 1.

## Timing
- `tready` falls, and `txd` falls (start bit), in the cycle after the handshake edge. `busy` rises in the same cycle.
- Frame length N = (1 + DATA_WIDTH + `parity_en` + 1 + `two_stop`) × P clocks, where P = `max(prescale,1)`×8.
- After those N clocks, state=IDLE: `busy`=0 and `tready`=1 in the same cycle.
- Minimum handshake-to-handshake spacing is N+1 clocks. Between back-to-back frames `txd` stays high for exactly one extra clock after the stop bit(s).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Shared package / header `uart_pkg`:**
  - state encoding
  - `OVERSAMPLE`=8, used by both `uart` RX and `uart_tx`
  - bit-timer width constant
- **Sub-module `uart_baud_timer`:**
  - loadable down-counter with `load`, `period` and `done` ports
  - reusable by the receiver
- Parity generation and the shift register stay in `uart_tx`.

## Test plan
- **Basic 8N1 frame:** `prescale`=10, 8N1, send 0x55.
  - `txd` is low for 80 clocks, then 1,0,1,0,1,0,1,0 at 80 clocks each, then high for 80.
  - `busy` is high for exactly 800 clocks; `tready` returns at clock 801.
- **Back-to-back:** 0x00 then 0xFF with `tvalid` held high, 8N1, `prescale`=10.
  - The second handshake is 801 clocks after the first.
  - The second start bit begins 802 clocks after the first handshake.
  - There is exactly one idle-high clock between the frames.
- **Parity:** `parity_en`=1, send 0x07.
  - Even parity: the 9th bit is 1. Odd parity: the 9th bit is 0.
  - With `two_stop`=1, the frame is 12×P and `txd` is high for 2P at the end.
- **Prescale edge cases:**
  - `prescale`=0: each bit is 8 clocks.
  - Changing `prescale` from 10 to 2 mid-frame: the current frame keeps 80-clock bits, and the next frame uses 16.
- **Reset mid-frame:** pull `rstn` low during bit 3 of 0xA5.
  - `txd`=1, `busy`=0 and `tready`=0 asynchronously.
  - After release, `tready`=1 on the next edge.
  - The next frame (0x3C) is bit-exact.
- **Random stress:** 1000 random bytes with random `tvalid` gaps, received by a `uart` RX model at the same `prescale`.
  - Received sequence equals the sent sequence.
  - No handshake occurs while `busy`=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths: state
// encoding, oversampling ratio and the bit-timer width and reload value.
package uart_pkg;

    // Clocks per bit for each unit of prescale.
    localparam int OVERSAMPLE = 8;

    // 65535 * 8 fits in 19 bits, so the bit timer never overflows.
    localparam int BIT_TIMER_W = 19;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Reload value for the bit timer: max(prescale,1) * OVERSAMPLE - 1.
    function automatic logic [BIT_TIMER_W-1:0] bit_period_m1(input logic [15:0] prescale);
        logic [BIT_TIMER_W-1:0] ps;
        ps = (prescale == 16'd0) ? BIT_TIMER_W'(1) : BIT_TIMER_W'(prescale);
        return ps * BIT_TIMER_W'(OVERSAMPLE) - BIT_TIMER_W'(1);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte stream into the transmitter.
// Handshake: a byte transfers on a rising clock edge where tvalid and tready
// are both high; the master holds tdata stable while tvalid is high and not
// yet accepted, and tready never depends combinationally on tvalid.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/uart_baud_timer.sv
// Loadable bit-period down-counter. done is high while the count is zero;
// the owner reloads it on the edge where the current bit ends.
module uart_baud_timer
    import uart_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   load,
    input  logic [BIT_TIMER_W-1:0] period,
    output logic                   done
);

    logic [BIT_TIMER_W-1:0] count_q;
    logic [BIT_TIMER_W-1:0] count_d;

    // Next count: reload wins, otherwise count down and rest at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = period;
        end else if (count_q != '0) begin
            count_d = count_q - BIT_TIMER_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity, one or two stop bits. Frame settings are captured at the
// handshake so the inputs may change while a frame is on the wire.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic      clk,
    input  logic      rstn,
    uart_tx_if.slave  s_axis,
    input  logic [15:0] prescale,
    input  logic      parity_en,
    input  logic      parity_odd,
    input  logic      two_stop,
    output logic      txd,
    output logic      busy,
    output tx_state_t state_o
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_t              state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [BIT_TIMER_W-1:0] period_q, period_d;
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
    logic                   two_stop_q, two_stop_d;
    logic                   txd_q, txd_d;
    logic                   busy_q, busy_d;
    logic                   tready_q, tready_d;

    logic                   timer_load;
    logic [BIT_TIMER_W-1:0] timer_period;
    logic                   bit_done;

    // In IDLE the timer is loaded straight from the live prescale input on the
    // handshake edge; afterwards it reloads from the captured frame period.
    assign timer_period = (state_q == ST_IDLE) ? bit_period_m1(prescale) : period_q;

    uart_baud_timer u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .load   (timer_load),
        .period (timer_period),
        .done   (bit_done)
    );

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        period_d   = period_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        tready_d   = tready_q;
        timer_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d    = 1'b1;
                busy_d   = 1'b0;
                tready_d = 1'b1;
                if (s_axis.tvalid && tready_q) begin
                    shift_d    = s_axis.tdata;
                    period_d   = bit_period_m1(prescale);
                    par_en_d   = parity_en;
                    par_bit_d  = (^s_axis.tdata) ^ parity_odd;
                    two_stop_d = two_stop;
                    state_d    = ST_START;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                    tready_d   = 1'b0;
                    timer_load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d    = ST_DATA;
                    txd_d      = shift_q[0];
                    shift_d    = shift_q >> 1;
                    bit_cnt_d  = '0;
                    timer_load = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    timer_load = 1'b1;
                    if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            txd_d   = par_bit_q;
                        end else begin
                            state_d    = ST_STOP;
                            txd_d      = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d    = ST_STOP;
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                    timer_load = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (two_stop_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                        timer_load = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        txd_d    = 1'b1;
                        busy_d   = 1'b0;
                        tready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                txd_d    = 1'b1;
                busy_d   = 1'b0;
                tready_d = 1'b0;
            end
        endcase
    end

    // State register; reset parks the line high and withholds tready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            tready_q <= tready_d;
        end
    end

    // Frame datapath registers: shift register, counters and captured settings.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            period_q   <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            period_q   <= period_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
        end
    end

    assign s_axis.tready = tready_q;
    assign txd           = txd_q;
    assign busy          = busy_q;
    assign state_o       = state_q;

endmodule
